// File: rtl/rf_multiport.sv
// Multi-port register file with combinational reads, one write port and a
// DEPTH-cycle clear sweep. Define RF_BYPASS_EN to forward same-cycle writes to reads.
module rf_multiport #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      RegWrite,
    input  logic [AW-1:0]             WriteRegister,
    input  logic [WIDTH-1:0]          WriteData,
    input  logic [NRD-1:0][AW-1:0]    ReadRegister,
    output logic [NRD-1:0][WIDTH-1:0] ReadData,
    input  logic                      ClearReq,
    output logic                      ClearBusy,
    output logic                      WriteDropped,
    output logic                      dbg_state
);

    localparam bit          ZR       = (ZERO_REG != 0);
    localparam logic [AW-1:0] ZERO_IDX = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             write_valid;

    // RegWrite and ClearReq are single-cycle qualifiers sampled on every rising
    // edge with no ready back-pressure: a write offered during a sweep is lost
    // and reported through WriteDropped instead of being stalled.
    assign write_valid = RegWrite && !(ZR && (WriteRegister == ZERO_IDX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            WriteDropped <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (write_valid) begin
                        mem[WriteRegister] <= WriteData;
                    end
                    if (ClearReq) begin
                        state        <= CLEAR;
                        cnt          <= '0;
                        WriteDropped <= 1'b0;
                    end
                end
                CLEAR: begin
                    mem[cnt] <= '0;
                    cnt      <= cnt + 1'b1;
                    if (write_valid) begin
                        WriteDropped <= 1'b1;
                    end
                    if (cnt == ZERO_IDX) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ClearBusy = (state == CLEAR);
    assign dbg_state = state;

    always_comb begin
        ReadData = '0;
        for (int i = 0; i < NRD; i++) begin
            ReadData[i] = mem[ReadRegister[i]];
            if (ZR && (ReadRegister[i] == ZERO_IDX)) begin
                ReadData[i] = '0;
            end
`ifdef RF_BYPASS_EN
            // Forwarding only applies when the write will actually land.
            if ((state == IDLE) && write_valid && (ReadRegister[i] == WriteRegister)) begin
                ReadData[i] = WriteData;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed self-checking bench for rf_multiport (WIDTH=64, DEPTH=32, NRD=2, ZERO_REG=1).
module tb_rf_multiport;

    logic             clk;
    logic             rst_n;
    logic             RegWrite;
    logic [4:0]       WriteRegister;
    logic [63:0]      WriteData;
    logic [1:0][4:0]  rd_reg;
    logic [1:0][63:0] rd_data;
    logic             ClearReq;
    logic             ClearBusy;
    logic             WriteDropped;
    logic             dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    rf_multiport #(.WIDTH(64), .DEPTH(32), .NRD(2), .ZERO_REG(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .ReadRegister (rd_reg),
        .ReadData     (rd_data),
        .ClearReq     (ClearReq),
        .ClearBusy    (ClearBusy),
        .WriteDropped (WriteDropped),
        .dbg_state    (dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [63:0] data);
        RegWrite      = 1'b1;
        WriteRegister = idx;
        WriteData     = data;
        tick();
        RegWrite = 1'b0;
    endtask

    task automatic pulse_clear();
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (ClearBusy && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (ClearBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", ClearBusy);
        end
        n_checks++;
        if (WriteDropped !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dropped: got %b expected 0", WriteDropped);
        end
        tick();
        tick();
        rd_reg[0] = 5'd0;
        rd_reg[1] = 5'd17;
        #1;
        n_checks++;
        if (rd_data[0] !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_r0: got %h expected 0", rd_data[0]);
        end
        n_checks++;
        if (rd_data[1] !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_r17: got %h expected 0", rd_data[1]);
        end
        tick();
        rst_n = 1'b1;
        write_reg(5'd1, 64'hCAFE);
        rd_reg[0] = 5'd1;
        #1;
        n_checks++;
        if (rd_data[0] !== 64'hCAFE) begin
            n_fail++;
            $display("FAIL first_write_after_reset: got %h expected %h", rd_data[0], 64'hCAFE);
        end
    endtask

    task automatic test_basic();
        write_reg(5'd5, 64'h1234);
        rd_reg[0] = 5'd5;
        rd_reg[1] = 5'd5;
        #1;
        n_checks++;
        if (rd_data[0] !== 64'h1234) begin
            n_fail++;
            $display("FAIL basic_r5_p0: got %h expected %h", rd_data[0], 64'h1234);
        end
        n_checks++;
        if (rd_data[1] !== 64'h1234) begin
            n_fail++;
            $display("FAIL basic_r5_p1: got %h expected %h", rd_data[1], 64'h1234);
        end
        rd_reg[1] = 5'd31;
        #1;
        n_checks++;
        if (rd_data[1] !== 64'h0) begin
            n_fail++;
            $display("FAIL basic_r31: got %h expected 0", rd_data[1]);
        end
    endtask

    task automatic test_zero_reg();
        write_reg(5'd31, 64'hDEAD);
        rd_reg[0] = 5'd31;
        #1;
        n_checks++;
        if (rd_data[0] !== 64'h0) begin
            n_fail++;
            $display("FAIL zero_reg_read: got %h expected 0", rd_data[0]);
        end
        n_checks++;
        if (WriteDropped !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_dropped: got %b expected 0", WriteDropped);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_same;
        write_reg(5'd7, 64'h1111);
`ifdef RF_BYPASS_EN
        exp_same = 64'hBEEF;
`else
        exp_same = 64'h1111;
`endif
        RegWrite      = 1'b1;
        WriteRegister = 5'd7;
        WriteData     = 64'hBEEF;
        rd_reg[0]     = 5'd7;
        rd_reg[1]     = 5'd5;
        #1;
        n_checks++;
        if (rd_data[0] !== exp_same) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h expected %h", rd_data[0], exp_same);
        end
        n_checks++;
        if (rd_data[1] !== 64'h1234) begin
            n_fail++;
            $display("FAIL bypass_other_port: got %h expected %h", rd_data[1], 64'h1234);
        end
        tick();
        RegWrite = 1'b0;
        #1;
        n_checks++;
        if (rd_data[0] !== 64'hBEEF) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: got %h expected %h", rd_data[0], 64'hBEEF);
        end
    endtask

    task automatic test_clear_sweep();
        int busy;
        for (int i = 0; i < 31; i++) begin
            write_reg(5'(i), 64'(i + 1));
        end
        pulse_clear();
        busy = 0;
        for (int k = 0; k < 100; k++) begin
            if (!ClearBusy) break;
            if (k == 10) begin
                rd_reg[0] = 5'd9;
                rd_reg[1] = 5'd10;
                #1;
                n_checks++;
                if (rd_data[0] !== 64'h0) begin
                    n_fail++;
                    $display("FAIL sweep_r9_k10: got %h expected 0", rd_data[0]);
                end
                n_checks++;
                if (rd_data[1] !== 64'd11) begin
                    n_fail++;
                    $display("FAIL sweep_r10_k10: got %h expected %h", rd_data[1], 64'd11);
                end
            end
            ClearReq = (k == 20);
            busy++;
            tick();
        end
        ClearReq = 1'b0;
        n_checks++;
        if (busy !== 32) begin
            n_fail++;
            $display("FAIL sweep_busy_cycles: got %0d expected 32", busy);
        end
        tick();
        n_checks++;
        if (ClearBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_no_restart: got %b expected 0", ClearBusy);
        end
        for (int i = 0; i < 32; i++) begin
            rd_reg[0] = 5'(i);
            rd_reg[1] = 5'(31 - i);
            #1;
            n_checks++;
            if (rd_data[0] !== 64'h0 || rd_data[1] !== 64'h0) begin
                n_fail++;
                $display("FAIL sweep_all_zero[%0d]: got %h/%h expected 0/0", i, rd_data[0], rd_data[1]);
            end
        end
    endtask

    task automatic test_write_with_clear();
        int cycles;
        RegWrite      = 1'b1;
        WriteRegister = 5'd2;
        WriteData     = 64'h77;
        ClearReq      = 1'b1;
        tick();
        RegWrite  = 1'b0;
        ClearReq  = 1'b0;
        rd_reg[0] = 5'd2;
        #1;
        n_checks++;
        if (rd_data[0] !== 64'h77) begin
            n_fail++;
            $display("FAIL write_with_clear_k0: got %h expected %h", rd_data[0], 64'h77);
        end
        tick();
        tick();
        write_reg(5'd31, 64'h99);
        wait_idle(cycles);
        n_checks++;
        if (cycles >= 100) begin
            n_fail++;
            $display("FAIL write_with_clear_idle: got timeout expected idle");
        end
        #1;
        n_checks++;
        if (rd_data[0] !== 64'h0) begin
            n_fail++;
            $display("FAIL write_with_clear_r2: got %h expected 0", rd_data[0]);
        end
        n_checks++;
        if (WriteDropped !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_write_in_sweep: got %b expected 0", WriteDropped);
        end
    endtask

    task automatic test_write_drop();
        int cycles;
        write_reg(5'd3, 64'h33);
        pulse_clear();
        for (int k = 0; k < 5; k++) tick();
        write_reg(5'd3, 64'h55);
        wait_idle(cycles);
        n_checks++;
        if (cycles >= 100) begin
            n_fail++;
            $display("FAIL drop_idle: got timeout expected idle");
        end
        rd_reg[0] = 5'd3;
        #1;
        n_checks++;
        if (rd_data[0] !== 64'h0) begin
            n_fail++;
            $display("FAIL drop_r3: got %h expected 0", rd_data[0]);
        end
        n_checks++;
        if (WriteDropped !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_flag_set: got %b expected 1", WriteDropped);
        end
        tick();
        n_checks++;
        if (WriteDropped !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_flag_sticky: got %b expected 1", WriteDropped);
        end
        pulse_clear();
        n_checks++;
        if (WriteDropped !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_flag_cleared: got %b expected 0", WriteDropped);
        end
        wait_idle(cycles);
    endtask

    task automatic test_reset_mid_sweep();
        write_reg(5'd4, 64'h44);
        write_reg(5'd20, 64'h2020);
        pulse_clear();
        for (int k = 0; k < 10; k++) tick();
        write_reg(5'd8, 64'h88);
        tick();
        n_checks++;
        if (WriteDropped !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre_dropped: got %b expected 1", WriteDropped);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ClearBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_busy: got %b expected 0", ClearBusy);
        end
        n_checks++;
        if (WriteDropped !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_dropped: got %b expected 0", WriteDropped);
        end
        rd_reg[0] = 5'd20;
        rd_reg[1] = 5'd4;
        #1;
        n_checks++;
        if (rd_data[0] !== 64'h0 || rd_data[1] !== 64'h0) begin
            n_fail++;
            $display("FAIL midreset_regs: got %h/%h expected 0/0", rd_data[0], rd_data[1]);
        end
        tick();
        rst_n = 1'b1;
        write_reg(5'd6, 64'h66);
        rd_reg[0] = 5'd6;
        #1;
        n_checks++;
        if (rd_data[0] !== 64'h66) begin
            n_fail++;
            $display("FAIL midreset_write_after: got %h expected %h", rd_data[0], 64'h66);
        end
        n_checks++;
        if (ClearBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stays_idle: got %b expected 0", ClearBusy);
        end
    endtask

    initial begin
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        rd_reg        = '0;
        ClearReq      = 1'b0;
        rst_n         = 1'b0;

        test_reset();
        test_basic();
        test_zero_reg();
        test_bypass();
        test_clear_sweep();
        test_write_with_clear();
        test_write_drop();
        test_reset_mid_sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning register data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of registers (power of two, >=4); AW = $clog2(DEPTH).
REQ-003 The block SHALL have parameter NRD, default 2, meaning number of independent read ports (1..4).
REQ-004 The block SHALL have parameter ZERO_REG, default 1, meaning register DEPTH-1 is hardwired zero when 1 and is an ordinary register when 0.
REQ-005 The block SHALL have port clk, input, 1 bit, the sole clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port RegWrite, input, 1 bit, write enable.
REQ-008 The block SHALL have port WriteRegister, input, AW bits, write index.
REQ-009 The block SHALL have port WriteData, input, WIDTH bits, write data.
REQ-010 The block SHALL have port ReadRegister, input, NRD x AW bits, read index per port.
REQ-011 The block SHALL have port ReadData, output, NRD x WIDTH bits, read data per port.
REQ-012 The block SHALL have port ClearReq, input, 1 bit, request to zero the whole file.
REQ-013 The block SHALL have port ClearBusy, output, 1 bit, high while a clear sweep is in progress.
REQ-014 The block SHALL have port WriteDropped, output, 1 bit, sticky flag set when a write is discarded during a clear.

Function
REQ-015 Reads SHALL be combinational: ReadData[i] = mem[ReadRegister[i]] in the same cycle, with zero latency.
REQ-016 When ZERO_REG=1, ReadData[i] SHALL be 0 for ReadRegister[i]==DEPTH-1, and writes to DEPTH-1 SHALL be discarded without setting WriteDropped.
REQ-017 In IDLE with RegWrite=1, mem[WriteRegister] SHALL take WriteData at the next rising edge.
REQ-018 The FSM SHALL have two states. IDLE moves to CLEAR on a rising edge with ClearReq=1 and loads the sweep counter with 0. CLEAR zeroes mem[counter] each edge and increments the counter. CLEAR moves to IDLE on the edge that zeroes index DEPTH-1.
REQ-019 ClearBusy SHALL equal (state==CLEAR); it is high for exactly DEPTH cycles per sweep, beginning the cycle after ClearReq is sampled.
REQ-020 ClearReq SHALL be ignored while in CLEAR, with no restart and no extension.
REQ-021 Simultaneous RegWrite and ClearReq in IDLE SHALL perform the write; the following sweep then zeroes it.
REQ-022 In CLEAR, RegWrite=1 SHALL be discarded and SHALL set WriteDropped; WriteDropped clears only on reset or on entry to CLEAR.
REQ-023 Reads during CLEAR SHALL return current contents: zero for indices below the counter, old values at or above it.

Reset
REQ-024 rst_n=0 SHALL asynchronously zero all registers, force IDLE, set the counter to 0, and drive ClearBusy=0 and WriteDropped=0.
REQ-025 Reset asserted mid-sweep SHALL abort the sweep; after release the block is in IDLE with all registers zero.
REQ-026 The first write after release SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-027 With macro RF_BYPASS_EN defined, when state is IDLE, RegWrite=1, and ReadRegister[i]==WriteRegister (and the index is not the zero register), ReadData[i] SHALL equal WriteData in the same cycle.
REQ-028 Without RF_BYPASS_EN, ReadData[i] SHALL return the pre-write contents in that cycle and the new value from the next cycle.

Verification
REQ-029 The bench SHALL cover this case: reset, then write 0x1234 to r5, then read r5 on both ports next cycle -> both ports show 0x1234; a read of r31 shows 0.
REQ-030 The bench SHALL cover this case: write 0xDEAD to r31 (ZERO_REG=1), then read r31 -> 0, and WriteDropped stays 0.
REQ-031 The bench SHALL cover this case: write 0xBEEF to r7 while ReadRegister[0]=7 in the same cycle -> ReadData[0]=0xBEEF with RF_BYPASS_EN, or the old value without it.
REQ-032 The bench SHALL cover this case: fill r0..r30 with index+1, then pulse ClearReq -> ClearBusy is high for 32 cycles; at sweep cycle 10, r9 reads 0 and r10 reads 11; all registers read 0 after the sweep.
REQ-033 The bench SHALL cover this case: RegWrite r3=0x55 at sweep cycle 5 -> r3 reads 0 after the sweep and WriteDropped=1; a subsequent ClearReq clears WriteDropped.
REQ-034 The bench SHALL cover this case: assert rst_n=0 at sweep cycle 12 -> ClearBusy=0 immediately and all registers 0; a write after release succeeds.
